memory_access_unit: RTL

Sits between the control unit's memory request outputs and a single-port, word-organised data BRAM. It accepts one byte-addressed load or store request at a time, encoded with RV32I `funct3`. For loads it performs byte-lane alignment and sign or zero extension. For byte and halfword stores it performs a read-modify-write, so the BRAM needs no byte strobes. Misaligned and illegal accesses are flagged and never touch memory.

---
 rtl/memory_access_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/memory_access_unit.sv
// Byte-addressed RV32I load/store front end for a word-wide, strobe-less BRAM.
// Loads are lane-aligned and extended; sub-word stores use read-modify-write.
module memory_access_unit #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_address,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_misaligned,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_RESPOND
    } state_t;

    state_t                  state_q, state_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   word_addr_q, word_addr_d;
    logic [1:0]              offset_q, offset_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    misaligned_q, misaligned_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;

    logic                    req_legal;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic                    sign_ext;
    logic [31:0]             load_word;
    logic [31:0]             merged_word;
    logic                    unused_bits;

    assign unused_bits = ^{req_address[31:ADDR_WIDTH+2], wdata_q[31:16]};

    always_comb begin
        req_legal = 1'b0;
        case (req_funct3)
            3'b000:  req_legal = 1'b1;
            3'b001:  req_legal = ~req_address[0];
            3'b010:  req_legal = (req_address[1:0] == 2'b00);
            3'b100:  req_legal = ~req_write;
            3'b101:  req_legal = ~req_write & ~req_address[0];
            default: req_legal = 1'b0;
        endcase
    end

    // Load formatting: lane select by latched offset, extension by funct3[2].
    assign byte_sel = mem_rdata[{offset_q, 3'b000} +: 8];
    assign half_sel = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign sign_ext = ~funct3_q[2];

    always_comb begin
        load_word = mem_rdata;
        case (funct3_q[1:0])
            2'b00:   load_word = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            2'b01:   load_word = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: load_word = mem_rdata;
        endcase
    end

    // Store merge: each lane either keeps the read byte or takes the store byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       lane_hit;
            logic [7:0] store_byte;
            assign lane_hit   = (funct3_q[1:0] == 2'b00) ? (offset_q == LANE)
                                                         : (offset_q[1] == LANE[1]);
            assign store_byte = (funct3_q[0] && LANE[0]) ? wdata_q[15:8] : wdata_q[7:0];
            assign merged_word[8*gi +: 8] = lane_hit ? store_byte : mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        word_addr_d  = word_addr_q;
        offset_d     = offset_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        misaligned_d = misaligned_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d     = req_write;
                    word_addr_d = req_address[ADDR_WIDTH+1:2];
                    offset_d    = req_address[1:0];
                    funct3_d    = req_funct3;
                    wdata_d     = req_wdata;
                    if (!req_legal) begin
                        rdata_d      = 32'd0;
                        misaligned_d = 1'b1;
                        state_d      = S_RESPOND;
                    end else if (req_write && req_funct3 == 3'b010) begin
                        mem_addr_d  = req_address[ADDR_WIDTH+1:2];
                        mem_wdata_d = req_wdata;
                        state_d     = S_WRITE;
                    end else begin
                        mem_addr_d = req_address[ADDR_WIDTH+1:2];
                        state_d    = S_READ;
                    end
                end
            end
            S_READ: state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (!write_q) begin
                    rdata_d      = load_word;
                    misaligned_d = 1'b0;
                    state_d      = S_RESPOND;
                end else begin
                    mem_wdata_d = merged_word;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                rdata_d      = 32'd0;
                misaligned_d = 1'b0;
                state_d      = S_RESPOND;
            end
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            word_addr_q  <= '0;
            offset_q     <= 2'd0;
            funct3_q     <= 3'd0;
            wdata_q      <= 32'd0;
            rdata_q      <= 32'd0;
            misaligned_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            word_addr_q  <= word_addr_d;
            offset_q     <= offset_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            misaligned_q <= misaligned_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign rsp_valid      = (state_q == S_RESPOND);
    assign mem_we         = (state_q == S_WRITE);
    assign rsp_rdata      = rdata_q;
    assign rsp_misaligned = misaligned_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;

endmodule
